hsync_line_tracker: RTL

Receive-side counterpart of the horizontal timing generator. The block watches an active-low horizontal sync, measures the line period and sync pulse width in pixel-clock-enable ticks, and declares lock after a run of consistent lines. Once locked, it regenerates a free-running horizontal position that is re-aligned on every good sync edge. It feeds capture, scaler and overlay logic that needs a horizontal position but only has the sync.

---
 rtl/video_timing_pkg.sv | 14 +
 rtl/edge_sampler.sv | 26 ++
 rtl/hsync_line_tracker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared horizontal timing definitions for the sync tracker and its generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } ht_state_t;

  // Default line shape produced by the matching timing generator.
  localparam int DEF_LINE = 384;
  localparam int DEF_SYNC = 32;

endpackage

// File: rtl/edge_sampler.sv
// Tick-gated sample register with falling/rising edge detect on a sync input.
// The edge strobes are only asserted on enabled ticks, so they can be used
// directly as "this tick saw an edge" qualifiers. Reusable for vertical sync.
module edge_sampler #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic fe,
  output logic re
);

  logic q;

  // Hold the previous tick's sample; idle level after reset is high.
  always_ff @(posedge clk) begin
    if (reset)   q <= INIT;
    else if (ce) q <= din;
  end

  assign fe = ce &  q & ~din;
  assign re = ce & ~q &  din;

endmodule

// File: rtl/hsync_line_tracker.sv
// Horizontal sync tracker: measures line period and sync width, locks after a
// run of consistent lines and regenerates a free-running hpos aligned to sync.
module hsync_line_tracker
  import video_timing_pkg::*;
#(
  parameter int HW         = 10,
  parameter int MIN_LINE   = 256,
  parameter int MAX_LINE   = 1000,
  parameter int TOL        = 2,
  parameter int LOCK_LINES = 4,
  parameter int MISS_MAX   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          hsync_n,
  output logic [HW-1:0] hpos,
  output logic [HW-1:0] line_len,
  output logic [HW-1:0] sync_width,
  output logic          locked,
  output logic          line_start,
  output logic          sync_err
);

  localparam int MW = $clog2(LOCK_LINES + 1);
  localparam int XW = $clog2(MISS_MAX + 1);
  localparam logic [HW-1:0] CNT_MAX   = '1;
  localparam logic [HW-1:0] MIN_W     = HW'(MIN_LINE);
  localparam logic [HW-1:0] MAX_W     = HW'(MAX_LINE);
  localparam logic [HW:0]   TOL_W     = (HW+1)'(TOL);
  localparam logic [MW-1:0] MATCH_TOP = MW'(LOCK_LINES - 1);
  localparam logic [XW-1:0] MISS_TOP  = XW'(MISS_MAX);

  ht_state_t     state;
  logic          fe, re;
  logic [HW-1:0] per_cnt, wid_cnt, ref_len, hpos_inc;
  logic [MW-1:0] match_cnt;
  logic [XW-1:0] miss_cnt;
  logic          period_ok, resync_ok, timeout, wrap;

  // |a - b| evaluated one bit wider so the subtraction cannot wrap.
  function automatic logic [HW:0] absdiff(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[HW] ? (~d + (HW+1)'(1)) : d;
  endfunction

  edge_sampler #(.INIT(1'b1)) u_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (hsync_n),
    .fe    (fe),
    .re    (re)
  );

  assign period_ok = (per_cnt >= MIN_W) && (per_cnt <= MAX_W) &&
                     (absdiff(per_cnt, ref_len) <= TOL_W);
  assign resync_ok = absdiff(per_cnt, line_len) <= TOL_W;
  assign timeout   = per_cnt > MAX_W;
  assign wrap      = hpos == (line_len - 1'b1);
  assign hpos_inc  = wrap ? '0 : hpos + 1'b1;
  assign locked    = state == LOCKED;

  // Period counter (saturating, reloads on sync fall) and low-pulse width.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt    <= '0;
      wid_cnt    <= '0;
      sync_width <= '0;
    end else if (ce) begin
      if (fe)                      per_cnt <= HW'(1);
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;

      if (fe) begin
        wid_cnt <= HW'(1);
      end else if (re) begin
        wid_cnt    <= '0;
        sync_width <= wid_cnt;
      end else if (!hsync_n && wid_cnt != CNT_MAX) begin
        wid_cnt <= wid_cnt + 1'b1;
      end
    end
  end

  // Lock FSM and regenerated position; pulses are cleared every clk so they
  // stay one clk wide even when ce is sparse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      ref_len    <= '0;
      hpos       <= '0;
      line_len   <= '0;
      line_start <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      line_start <= 1'b0;
      sync_err   <= 1'b0;
      if (ce) begin
        if (timeout && !fe) begin
          // Sync vanished: silent drop to IDLE, no error pulse, no line_start.
          state     <= IDLE;
          match_cnt <= '0;
          miss_cnt  <= '0;
          hpos      <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              hpos <= '0;
              if (fe) begin
                state     <= MEASURE;
                match_cnt <= '0;
              end
            end
            MEASURE: begin
              hpos <= '0;
              if (fe) begin
                ref_len <= per_cnt;
                if (!period_ok) begin
                  match_cnt <= '0;
                end else if (match_cnt + 1'b1 >= MATCH_TOP) begin
                  match_cnt  <= '0;
                  miss_cnt   <= '0;
                  line_len   <= per_cnt;
                  line_start <= 1'b1;
                  state      <= LOCKED;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end
            end
            LOCKED: begin
              if (fe && resync_ok) begin
                hpos       <= '0;
                line_start <= 1'b1;
                miss_cnt   <= '0;
              end else if (fe && (miss_cnt + 1'b1 >= MISS_TOP)) begin
                // Too many bad edges: fall back and re-measure from this edge.
                sync_err  <= 1'b1;
                state     <= MEASURE;
                match_cnt <= '0;
                miss_cnt  <= '0;
                ref_len   <= per_cnt;
                hpos      <= '0;
              end else begin
                if (fe) begin
                  sync_err <= 1'b1;
                  miss_cnt <= miss_cnt + 1'b1;
                end
                hpos       <= hpos_inc;
                line_start <= wrap;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
